// File: rtl/demux_ula_pkg.sv
// Shared types for the ALU result demultiplexer.
// Holds the destination flag encodings, the default word width and the
// FIFO entry layout {flag, dado} used at the default width.
package demux_ula_pkg;

    localparam int LARGURA_PADRAO = 32;

    typedef enum logic [1:0] {
        DEST_SAIDA1 = 2'b00,
        DEST_SAIDA2 = 2'b01,
        DEST_SAIDA3 = 2'b10,
        DEST_SAIDA4 = 2'b11
    } destino_t;

    typedef struct packed {
        logic [1:0]                flag;
        logic [LARGURA_PADRAO-1:0] dado;
    } item_t;

endpackage

// File: rtl/fifo_ula.sv
// Purpose: synchronous FIFO of routed ALU words (entry type is a parameter).
// Latency: a word written at edge N is at the head from cycle N+1; no bypass.
// Backpressure: push ignored when cheio, pop ignored when vazio; callers gate.
// Ports: clock, reset_n (async active-low), push/dado_in, pop/dado_out (head),
//        ocupacao (words stored), vazio, cheio.
module fifo_ula
    import demux_ula_pkg::*;
#(
    parameter type T_ITEM       = item_t,
    parameter int  PROFUNDIDADE = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          push,
    input  T_ITEM                         dado_in,
    input  logic                          pop,
    output T_ITEM                         dado_out,
    output logic [$clog2(PROFUNDIDADE):0] ocupacao,
    output logic                          vazio,
    output logic                          cheio
);

    localparam int                AW       = $clog2(PROFUNDIDADE);
    localparam logic [AW-1:0]     PTR_UM   = 1;
    localparam logic [AW:0]       OCUP_UM  = 1;
    localparam logic [AW:0]       OCUP_MAX = PROFUNDIDADE[AW:0];

    T_ITEM          mem [PROFUNDIDADE];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign vazio   = (ocupacao == '0);
    assign cheio   = (ocupacao == OCUP_MAX);
    assign do_push = push && !cheio;
    assign do_pop  = pop && !vazio;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ocupacao <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_UM;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_UM;
            case ({do_push, do_pop})
                2'b10:   ocupacao <= ocupacao + OCUP_UM;
                2'b01:   ocupacao <= ocupacao - OCUP_UM;
                default: ocupacao <= ocupacao;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while not empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= dado_in;
    end

    assign dado_out = mem[rd_ptr];

endmodule

// File: rtl/demultiplexador_ula.sv
// Purpose: registered 1-to-4 demux of ALU results, strict FIFO order across ports.
// Latency: word pushed at edge N appears on its destination in cycle N+1.
// Backpressure: entrada_pronta = !cheio; a stalled head destination blocks all.
// Ports: clock, reset_n (async active-low); entrada/flag/entrada_valida/
//        entrada_pronta producer side; saida1..saida4, saida_valida[3:0],
//        saida_pronta[3:0] consumer side; ocupacao, vazio, cheio status.
// Optional: DEMUX_ULA_CONTADORES_EN adds contadores[63:0], four 16-bit wrapping
//           pop counters (field k = pops to saida k+1).
module demultiplexador_ula
    import demux_ula_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [LARGURA-1:0]            entrada,
    input  logic [1:0]                    flag,
    input  logic                          entrada_valida,
    output logic                          entrada_pronta,
    output logic [LARGURA-1:0]            saida1,
    output logic [LARGURA-1:0]            saida2,
    output logic [LARGURA-1:0]            saida3,
    output logic [LARGURA-1:0]            saida4,
    output logic [3:0]                    saida_valida,
    input  logic [3:0]                    saida_pronta,
    output logic [$clog2(PROFUNDIDADE):0] ocupacao,
    output logic                          vazio,
    output logic                          cheio
`ifdef DEMUX_ULA_CONTADORES_EN
    ,
    output logic [63:0]                   contadores
`endif
);

    // Same layout as demux_ula_pkg::item_t, but follows this instance's LARGURA.
    typedef struct packed {
        logic [1:0]         flag;
        logic [LARGURA-1:0] dado;
    } item_w_t;

    item_w_t item_in;
    item_w_t cabeca;
    logic    push;
    logic    pop;

    assign item_in.flag   = flag;
    assign item_in.dado   = entrada;
    assign entrada_pronta = !cheio;
    assign push           = entrada_valida && entrada_pronta;

    fifo_ula #(
        .T_ITEM       (item_w_t),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .dado_in  (item_in),
        .pop      (pop),
        .dado_out (cabeca),
        .ocupacao (ocupacao),
        .vazio    (vazio),
        .cheio    (cheio)
    );

    // Only the head's destination is qualified; ready bits of the others
    // are masked out by the AND below.
    always_comb begin
        saida_valida = '0;
        if (!vazio) begin
            case (destino_t'(cabeca.flag))
                DEST_SAIDA1: saida_valida = 4'b0001;
                DEST_SAIDA2: saida_valida = 4'b0010;
                DEST_SAIDA3: saida_valida = 4'b0100;
                DEST_SAIDA4: saida_valida = 4'b1000;
                default:     saida_valida = '0;
            endcase
        end
    end

    assign pop = |(saida_valida & saida_pronta);

    // Unselected ports are forced to zero so consumers never see stale data.
    assign saida1 = saida_valida[0] ? cabeca.dado : '0;
    assign saida2 = saida_valida[1] ? cabeca.dado : '0;
    assign saida3 = saida_valida[2] ? cabeca.dado : '0;
    assign saida4 = saida_valida[3] ? cabeca.dado : '0;

`ifdef DEMUX_ULA_CONTADORES_EN
    logic [15:0] cont [4];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) cont[k] <= '0;
        end else if (pop) begin
            cont[cabeca.flag] <= cont[cabeca.flag] + 16'd1;
        end
    end

    assign contadores = {cont[3], cont[2], cont[1], cont[0]};
`endif

endmodule

// File: tb/tb_demultiplexador_ula.sv
module tb_demultiplexador_ula;
    import demux_ula_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [31:0] entrada;
    logic [1:0]  flag;
    logic        entrada_valida;
    logic        entrada_pronta;
    logic [31:0] saida1, saida2, saida3, saida4;
    logic [3:0]  saida_valida;
    logic [3:0]  saida_pronta;
    logic [2:0]  ocupacao;
    logic        vazio, cheio;
`ifdef DEMUX_ULA_CONTADORES_EN
    logic [63:0] contadores;
`endif

    demultiplexador_ula #(.LARGURA(32), .PROFUNDIDADE(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .entrada        (entrada),
        .flag           (flag),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .saida1         (saida1),
        .saida2         (saida2),
        .saida3         (saida3),
        .saida4         (saida4),
        .saida_valida   (saida_valida),
        .saida_pronta   (saida_pronta),
        .ocupacao       (ocupacao),
        .vazio          (vazio),
        .cheio          (cheio)
`ifdef DEMUX_ULA_CONTADORES_EN
        ,
        .contadores     (contadores)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int    testes = 0;
    int    falhas = 0;
    item_t sb [$];

    typedef struct {
        logic [1:0]  flag;
        logic [31:0] dado;
        logic [3:0]  pronta;
        logic [3:0]  exp_valida;
    } vetor_t;
    vetor_t vetores [8];

    task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        testes++;
        if (atual !== esperado) begin
            falhas++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Holds the word valid until the block accepts it (bounded wait).
    task automatic push_word(input logic [1:0] f, input logic [31:0] d);
        bit aceito;
        aceito = 0;
        entrada        = d;
        flag           = f;
        entrada_valida = 1'b1;
        for (int c = 0; c < 20 && !aceito; c++) begin
            @(negedge clock);
            if (entrada_pronta) begin
                aceito = 1;
                @(posedge clock);
                #1;
            end
        end
        entrada_valida = 1'b0;
        if (!aceito) check("push_timeout", 64'd0, 64'd1);
    endtask

    // Scoreboard: record accepted pushes, compare each pop against the model.
    always @(negedge clock) begin
        item_t       e;
        item_t       n;
        logic [3:0]  ev;
        logic [31:0] pd;
        logic [31:0] outros;
        if (reset_n) begin
            if (|(saida_valida & saida_pronta)) begin
                if (sb.size() == 0) begin
                    check("pop_sem_item", {60'd0, saida_valida}, 64'd0);
                end else begin
                    e  = sb.pop_front();
                    ev = 4'b0001 << e.flag;
                    case (e.flag)
                        2'b00:   begin pd = saida1; outros = saida2 | saida3 | saida4; end
                        2'b01:   begin pd = saida2; outros = saida1 | saida3 | saida4; end
                        2'b10:   begin pd = saida3; outros = saida1 | saida2 | saida4; end
                        default: begin pd = saida4; outros = saida1 | saida2 | saida3; end
                    endcase
                    check("pop_valida", {60'd0, saida_valida}, {60'd0, ev});
                    check("pop_dado", {32'd0, pd}, {32'd0, e.dado});
                    check("pop_outros_zero", {32'd0, outros}, 64'd0);
                end
            end
            if (entrada_valida && entrada_pronta) begin
                n.flag = flag;
                n.dado = entrada;
                sb.push_back(n);
            end
        end
    end

    initial begin
        vetores[0] = '{2'b00, 32'h1111_0000, 4'b1111, 4'b0001};
        vetores[1] = '{2'b01, 32'h2222_0001, 4'b0010, 4'b0010};
        vetores[2] = '{2'b10, 32'h3333_0002, 4'b0100, 4'b0100};
        vetores[3] = '{2'b11, 32'h4444_0003, 4'b1000, 4'b1000};
        vetores[4] = '{2'b00, 32'hFFFF_FFFF, 4'b0001, 4'b0001};
        vetores[5] = '{2'b01, 32'h0000_0000, 4'b1111, 4'b0010};
        vetores[6] = '{2'b10, 32'hA5A5_5A5A, 4'b1110, 4'b0100};
        vetores[7] = '{2'b11, 32'h8000_0001, 4'b1001, 4'b1000};

        reset_n        = 1'b0;
        entrada        = '0;
        flag           = '0;
        entrada_valida = 1'b0;
        saida_pronta   = 4'b0000;
        #12;
        check("rst_vazio", {63'd0, vazio}, 64'd1);
        check("rst_cheio", {63'd0, cheio}, 64'd0);
        check("rst_pronta", {63'd0, entrada_pronta}, 64'd1);
        check("rst_valida", {60'd0, saida_valida}, 64'd0);
        check("rst_ocupacao", {61'd0, ocupacao}, 64'd0);
        check("rst_saidas", {32'd0, saida1 | saida2 | saida3 | saida4}, 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        tick();

        // Single word to saida3, consumer ready.
        saida_pronta = 4'b1111;
        push_word(2'b10, 32'h0000_00AA);
        check("t1_valida", {60'd0, saida_valida}, 64'h4);
        check("t1_saida3", {32'd0, saida3}, 64'hAA);
        check("t1_outros", {32'd0, saida1 | saida2 | saida4}, 64'd0);
        tick();
        check("t1_vazio", {63'd0, vazio}, 64'd1);

        // Fill to full, then drain one per cycle.
        saida_pronta = 4'b0000;
        for (int i = 0; i < 4; i++) push_word(i[1:0], 32'(i + 1));
        check("cheio_cheio", {63'd0, cheio}, 64'd1);
        check("cheio_pronta", {63'd0, entrada_pronta}, 64'd0);
        check("cheio_ocup", {61'd0, ocupacao}, 64'd4);
        check("cheio_valida", {60'd0, saida_valida}, 64'h1);
        saida_pronta = 4'b1111;
        tick();
        check("pronta_apos_pop", {63'd0, entrada_pronta}, 64'd1);
        check("ocup_apos_pop", {61'd0, ocupacao}, 64'd3);
        tick();
        tick();
        tick();
        check("dreno_vazio", {63'd0, vazio}, 64'd1);

        // Head-of-line stall: destination 2 not ready, others ready.
        saida_pronta = 4'b1101;
        push_word(2'b01, 32'hCAFE_0001);
        for (int c = 0; c < 10; c++) begin
            check("stall_valida", {60'd0, saida_valida}, 64'h2);
            check("stall_dado", {32'd0, saida2}, 64'hCAFE_0001);
            tick();
        end
        saida_pronta = 4'b1111;
        tick();
        check("stall_liberado", {63'd0, vazio}, 64'd1);

        // Table-driven single-word routing.
        for (int v = 0; v < 8; v++) begin
            saida_pronta = 4'b0000;
            push_word(vetores[v].flag, vetores[v].dado);
            check("tab_valida", {60'd0, saida_valida}, {60'd0, vetores[v].exp_valida});
            check("tab_ocup", {61'd0, ocupacao}, 64'd1);
            saida_pronta = vetores[v].pronta;
            tick();
            check("tab_vazio", {63'd0, vazio}, 64'd1);
        end

        // Streaming: push and pop every cycle, pointers wrap many times.
        saida_pronta = 4'b1111;
        for (int i = 0; i < 100; i++) begin
            entrada        = 32'h100 + 32'(i);
            flag           = i[1:0];
            entrada_valida = 1'b1;
            tick();
            check("stream_ocup", {61'd0, ocupacao}, 64'd1);
        end
        entrada_valida = 1'b0;
        tick();
        check("stream_vazio", {63'd0, vazio}, 64'd1);

        // Asynchronous reset with words stored.
        saida_pronta = 4'b0000;
        push_word(2'b00, 32'h0BAD_0001);
        push_word(2'b01, 32'h0BAD_0002);
        push_word(2'b10, 32'h0BAD_0003);
        check("pre_rst_ocup", {61'd0, ocupacao}, 64'd3);
        #2 reset_n = 1'b0;
        sb.delete();
        #1;
        check("arst_valida", {60'd0, saida_valida}, 64'd0);
        check("arst_ocup", {61'd0, ocupacao}, 64'd0);
        check("arst_vazio", {63'd0, vazio}, 64'd1);
        check("arst_saidas", {32'd0, saida1 | saida2 | saida3 | saida4}, 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        saida_pronta = 4'b1111;
        push_word(2'b11, 32'hDEAD_BEEF);
        check("pos_rst_valida", {60'd0, saida_valida}, 64'h8);
        check("pos_rst_saida4", {32'd0, saida4}, 64'hDEAD_BEEF);
        tick();

`ifdef DEMUX_ULA_CONTADORES_EN
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("cnt_reset", contadores, 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        saida_pronta   = 4'b1111;
        flag           = 2'b11;
        entrada_valida = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            entrada = 32'(i);
            tick();
        end
        entrada_valida = 1'b0;
        tick();
        tick();
        check("cnt_wrap", contadores, 64'h0001_0000_0000_0000);
`endif

        check("sb_drenado", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule

// File: doc/demultiplexador_ula.md
# demultiplexador_ula

Registered 1-to-4 demultiplexer for the processor's ALU result path: accepts a 32-bit word plus a 2-bit destination `flag` through a valid/ready handshake, buffers it in a small FIFO, and delivers it to exactly one of four destination ports, each with its own valid/ready handshake. It is the distribution-side counterpart of the ALU input multiplexer. It routes results from one ALU producer to the register file, memory, branch, and forwarding consumers without combinational paths between producer and consumers.

## Interface
- `LARGURA`, 32, data word width.
- `PROFUNDIDADE`, 4, FIFO depth in words; power of two, ≥ 2.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `entrada` in LARGURA: word to route.
- `flag` in 2: destination select. 00→saida1, 01→saida2, 10→saida3, 11→saida4.
- `entrada_valida` in 1: producer holds `entrada`/`flag` valid.
- `entrada_pronta` out 1: block can accept a word this cycle.
- `saida1`..`saida4` out LARGURA each: destination data.
- `saida_valida` out 4: bit i-1 qualifies `saidai`. At most one bit is high.
- `saida_pronta` in 4: bit i-1 means destination i accepts.
- `ocupacao` out $clog2(PROFUNDIDADE)+1: words stored.
- `vazio`, `cheio` out 1 each: ocupacao==0 / ocupacao==PROFUNDIDADE.

## Operation
- Push occurs when `entrada_valida && entrada_pronta`. The block stores {flag, entrada} at the write pointer.
- `entrada_pronta = !cheio`. It is registered-state only and does not depend on `saida_pronta` or `entrada_valida`.
- Head of FIFO: `saida_valida[head.flag]=1` when not empty. The selected `saidaN` carries head data. All unselected `saidaN` are driven to 0.
- Pop occurs when `saida_valida[k] && saida_pronta[k]` for the selected k. `saida_pronta` bits of unselected destinations are ignored.
- Ordering is strict FIFO across all destinations. A stalled destination blocks later words for other destinations (head-of-line blocking is intended).
- Push and pop in the same cycle: `ocupacao` is unchanged and both pointers advance. Push while full cannot occur because `entrada_pronta` is low.
- Pointers wrap modulo PROFUNDIDADE. `ocupacao` saturates neither way because the handshakes prevent overflow and underflow.
- Once `saida_valida` is asserted, head data and flag remain stable until popped.
- `flag` is sampled only on push. Its value at other times is irrelevant.

## Timing
- Reset (async assert, released synchronously to `clock` by the system): pointers = 0, `ocupacao` = 0, `vazio` = 1, `cheio` = 0, `entrada_pronta` = 1, `saida_valida` = 0, all `saidaN` = 0.
- Reset asserted mid-operation discards all stored words immediately. Outputs take their reset values asynchronously.
- Latency: a word pushed at edge N is visible at its destination after edge N, i.e. in cycle N+1. There is no same-cycle bypass when empty.
- Throughput is 1 word/cycle when the head destination keeps `saida_pronta` high.
- `entrada_pronta` rises in the cycle after a pop from a full FIFO.
- Outputs are driven from storage registers plus a combinational mux on head flag. There is no input-to-output combinational path.

## Configuration
- `DEMUX_ULA_CONTADORES_EN` defined:
  - Adds output `contadores` (64 bits = four 16-bit fields; field k counts pops to destination k+1).
  - Each field increments on its pop, wraps 0xFFFF→0x0000, and resets to 0.
- Undefined: the port and counters are absent. All other behaviour is identical.

## Structure
- Package `demux_ula_pkg`:
  - flag encodings `DEST_SAIDA1..DEST_SAIDA4` (2'b00..2'b11);
  - default `LARGURA`;
  - packed struct `item_t` {flag[1:0], dado[LARGURA-1:0]}.
- Sub-module `fifo_ula`: synchronous FIFO of `item_t`, same clock/reset, exposing push/pop/ocupacao/vazio/cheio. Top level adds routing, handshakes, and optional counters.

## Test plan
- Reset, then push 0x0000_00AA with flag=10 and all `saida_pronta`=1111.
  - Cycle after push: `saida_valida`=0100, `saida3`=0x0000_00AA, other outputs 0.
  - Pop that cycle; `vazio`=1 next cycle.
- `saida_pronta`=0000, push 4 words 0x1..0x4 with flags 00,01,10,11.
  - After the 4th: `cheio`=1, `entrada_pronta`=0.
  - Raise all `saida_pronta`: words emerge on saida1..saida4 in order, one per cycle.
- Head flag=01 with `saida_pronta`=1101: head stalls, `saida_valida`=0010 stable, data unchanged for 10 cycles.
  - Set bit 1: pop occurs.
- Continuous push/pop every cycle for 100 words: `ocupacao` stays 1, and order and pointer wrap are preserved.
- Deassert `reset_n` with 3 words stored: `saida_valida`=0 and `ocupacao`=0 immediately, without waiting for a clock edge.
  - After release, the first new push is delivered correctly.
- With `DEMUX_ULA_CONTADORES_EN`: 65537 pops to saida4 gives field 3 = 0x0001, other fields 0.
